btn_debounce_n: RTL and testbench

- Parametrised push-button front-end for the FPGA top level. Replaces the direct, unfiltered button-to-port wiring.
- Per channel it provides:
  - a two-flop synchroniser;
  - a counter-based debouncer;
  - press and release one-cycle pulses;
  - optional auto-repeat while the button is held;
  - a sticky pending bit with write-one-to-clear.
- Outputs feed the dmem_io button port, so software can poll pending events instead of raw levels.

---
 rtl/btn_debounce_n.sv | 147 ++++++++++++++
 tb/tb_btn_debounce_n.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_n.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_n
// Purpose  : Per-channel push-button front end. Each channel has a two-flop
//            synchroniser, a counter debouncer, press/release pulses,
//            optional auto-repeat and a sticky write-one-to-clear pending bit.
// Revision : 1.0  initial release
// ============================================================================
module btn_debounce_n #(
  parameter int N_BTN          = 4,
  parameter int DEBOUNCE_TICKS = 1000000,
  parameter int REPEAT_DELAY   = 0,
  parameter int REPEAT_TICKS   = 0,
  parameter int ACTIVE_LOW     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] clr,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_pending,
  output logic             any_pending
);

  // Counter widths hold the largest terminal value without wrapping.
  localparam int DCNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
  localparam int RCNT_W = ((REPEAT_DELAY + REPEAT_TICKS) > 1) ?
                          $clog2(REPEAT_DELAY + REPEAT_TICKS + 1) : 1;
  localparam logic [DCNT_W-1:0] C_DCNT_LAST = DCNT_W'(DEBOUNCE_TICKS - 1);

  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;

  // Polarity normalisation ahead of the two-flop synchroniser.
  always_comb begin
    sync1_d = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
    sync2_d = sync1_q;
  end

  // Synchroniser registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    logic              level_q, level_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              pending_q, pending_d;
    logic              rpt_hit;

    // Debounce, pulse generation and pending bookkeeping. Pending follows the
    // visible press pulse, so a clear in the same cycle as a pulse loses.
    always_comb begin
      level_d   = level_q;
      dcnt_d    = dcnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (sync2_q[i] == level_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == C_DCNT_LAST) begin
        level_d   = sync2_q[i];
        dcnt_d    = '0;
        press_d   = sync2_q[i];
        release_d = ~sync2_q[i];
      end else begin
        dcnt_d = dcnt_q + DCNT_W'(1);
      end
      // An accepted release suppresses a repeat that would land on the same edge.
      if (rpt_hit && !release_d) begin
        press_d = 1'b1;
      end
      pending_d = press_q | (pending_q & ~clr[i]);
    end

    // Per-channel state registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        level_q   <= 1'b0;
        dcnt_q    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        pending_q <= 1'b0;
      end else begin
        level_q   <= level_d;
        dcnt_q    <= dcnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        pending_q <= pending_d;
      end
    end

    if (REPEAT_DELAY > 0) begin : g_rpt
      localparam logic [RCNT_W-1:0] C_RPT_FIRST = RCNT_W'(REPEAT_DELAY - 1);
      localparam logic [RCNT_W-1:0] C_RPT_LAST  = RCNT_W'(REPEAT_DELAY + REPEAT_TICKS - 1);
      localparam logic [RCNT_W-1:0] C_RPT_WRAP  = RCNT_W'(REPEAT_DELAY);

      logic [RCNT_W-1:0] rcnt_q, rcnt_d;

      // rcnt is zero on the edge after the accepted press; it reaches
      // C_RPT_FIRST one cycle before the first repeat, then cycles between
      // C_RPT_WRAP and C_RPT_LAST for the periodic repeats.
      assign rpt_hit = level_q & ((rcnt_q == C_RPT_FIRST) | (rcnt_q == C_RPT_LAST));

      // Repeat counter: held at zero while released, otherwise advancing.
      always_comb begin
        rcnt_d = rcnt_q;
        if (!level_q) begin
          rcnt_d = '0;
        end else if (rcnt_q == C_RPT_LAST) begin
          rcnt_d = C_RPT_WRAP;
        end else begin
          rcnt_d = rcnt_q + RCNT_W'(1);
        end
      end

      // Repeat counter register.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rcnt_q <= '0;
        end else begin
          rcnt_q <= rcnt_d;
        end
      end
    end else begin : g_no_rpt
      assign rpt_hit = 1'b0;
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_pending[i] = pending_q;
  end

  assign any_pending = |btn_pending;

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_debounce_n
// Purpose  : Self-checking bench for btn_debounce_n. Three instances
//            (plain, auto-repeat, active-low) run against a history-based
//            reference model plus a few directed scenario checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_btn_debounce_n;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] raw  [3];
  logic [3:0] clr  [3];
  logic [3:0] lvl  [3];
  logic [3:0] prs  [3];
  logic [3:0] rls  [3];
  logic [3:0] pnd  [3];
  logic       anyp [3];

  always #5 clk = ~clk;

  btn_debounce_n #(.N_BTN(4), .DEBOUNCE_TICKS(4), .REPEAT_DELAY(0), .REPEAT_TICKS(0), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .reset(rst), .btn_raw(raw[0]), .clr(clr[0]),
    .btn_level(lvl[0]), .btn_press(prs[0]), .btn_release(rls[0]),
    .btn_pending(pnd[0]), .any_pending(anyp[0]));

  btn_debounce_n #(.N_BTN(4), .DEBOUNCE_TICKS(2), .REPEAT_DELAY(8), .REPEAT_TICKS(3), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .reset(rst), .btn_raw(raw[1]), .clr(clr[1]),
    .btn_level(lvl[1]), .btn_press(prs[1]), .btn_release(rls[1]),
    .btn_pending(pnd[1]), .any_pending(anyp[1]));

  btn_debounce_n #(.N_BTN(4), .DEBOUNCE_TICKS(4), .REPEAT_DELAY(0), .REPEAT_TICKS(0), .ACTIVE_LOW(1)) dut_c (
    .clk(clk), .reset(rst), .btn_raw(raw[2]), .clr(clr[2]),
    .btn_level(lvl[2]), .btn_press(prs[2]), .btn_release(rls[2]),
    .btn_pending(pnd[2]), .any_pending(anyp[2]));

  // Reference model configuration per instance.
  int cfg_dt [3] = '{4, 2, 4};
  int cfg_rd [3] = '{0, 8, 0};
  int cfg_rt [3] = '{0, 3, 0};
  bit cfg_al [3] = '{1'b0, 1'b0, 1'b1};

  // Model: sample history since reset, indexed by edge number (1 = first
  // edge after reset release), plus the model's view of each output.
  bit xh    [3][4][4096];
  bit m_lvl [3][4];
  bit m_prs [3][4];
  bit m_rls [3][4];
  bit m_pnd [3][4];
  int m_acc [3][4];
  int m_pe  [3][4];
  int ek;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 4; c++) begin
        m_lvl[i][c] = 1'b0;
        m_prs[i][c] = 1'b0;
        m_rls[i][c] = 1'b0;
        m_pnd[i][c] = 1'b0;
        m_acc[i][c] = 0;
        m_pe[i][c]  = 0;
      end
    end
    ek = 0;
  endfunction

  // One clock edge of the reference model. A level is accepted at edge k when
  // the DEBOUNCE_TICKS most recent synchronised samples (sample j reaches the
  // debouncer at edge j+2) all differ from the current level and all arrived
  // after the previous acceptance. Repeats fall at press + RD + m*RT.
  function automatic void model_edge();
    ek++;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 4; c++) begin
        int  n;
        int  lo;
        int  d;
        bit  pr;
        bit  rl;
        xh[i][c][ek] = raw[i][c] ^ cfg_al[i];
        m_pnd[i][c]  = m_prs[i][c] | (m_pnd[i][c] & ~clr[i][c]);
        n  = 0;
        lo = (m_acc[i][c] - 1 > 1) ? m_acc[i][c] - 1 : 1;
        for (int j = ek - 2; j >= lo && n < cfg_dt[i]; j--) begin
          if (xh[i][c][j] != m_lvl[i][c]) n++;
          else break;
        end
        pr = 1'b0;
        rl = 1'b0;
        if (n >= cfg_dt[i]) begin
          m_lvl[i][c] = ~m_lvl[i][c];
          m_acc[i][c] = ek;
          if (m_lvl[i][c]) begin
            pr = 1'b1;
            m_pe[i][c] = ek;
          end else begin
            rl = 1'b1;
          end
        end else if (m_lvl[i][c] && cfg_rd[i] > 0) begin
          d = ek - m_pe[i][c];
          if (d >= cfg_rd[i] && ((d - cfg_rd[i]) % cfg_rt[i]) == 0) pr = 1'b1;
        end
        m_prs[i][c] = pr;
        m_rls[i][c] = rl;
      end
    end
  endfunction

  task automatic check_zero();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_outs%0d", i), {16'h0, lvl[i], prs[i], rls[i], pnd[i]}, 32'h0);
      chk($sformatf("rst_any%0d", i), {31'h0, anyp[i]}, 32'h0);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      logic [3:0] el, ep, er, en;
      for (int c = 0; c < 4; c++) begin
        el[c] = m_lvl[i][c];
        ep[c] = m_prs[i][c];
        er[c] = m_rls[i][c];
        en[c] = m_pnd[i][c];
      end
      chk($sformatf("level%0d", i),   {28'h0, lvl[i]}, {28'h0, el});
      chk($sformatf("press%0d", i),   {28'h0, prs[i]}, {28'h0, ep});
      chk($sformatf("release%0d", i), {28'h0, rls[i]}, {28'h0, er});
      chk($sformatf("pending%0d", i), {28'h0, pnd[i]}, {28'h0, en});
      chk($sformatf("any%0d", i),     {31'h0, anyp[i]}, {31'h0, |en});
    end
  endtask

  // Inputs are set before calling; they are sampled at the coming rising edge
  // and the outputs are checked on the following falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    if (rst) check_zero();
    else     compare_all();
  endtask

  int hold [3][4];

  task automatic random_run(input int cycles, input int max_hold);
    for (int t = 0; t < cycles; t++) begin
      for (int i = 0; i < 3; i++) begin
        for (int c = 0; c < 4; c++) begin
          if (hold[i][c] == 0) begin
            raw[i][c]  = 1'($urandom_range(0, 1));
            hold[i][c] = $urandom_range(1, max_hold);
          end else begin
            hold[i][c]--;
          end
        end
        clr[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      end
      cycle();
    end
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    int found;
    raw[0] = 4'b0001;   // channel 0 held through reset
    raw[1] = 4'b1000;   // channel 3 held through reset (auto-repeat)
    raw[2] = 4'b1111;   // active-low idle
    for (int i = 0; i < 3; i++) clr[i] = 4'b0000;
    for (int i = 0; i < 3; i++) for (int c = 0; c < 4; c++) hold[i][c] = 0;
    model_reset();

    // Asynchronous assertion: outputs clear without a clock edge.
    #1 rst = 1'b1;
    #1 check_zero();
    cycle();
    cycle();
    rst = 1'b0;

    // Held-through-reset press and auto-repeat cadence.
    cnt_a = 0;
    cnt_b = 0;
    for (int t = 0; t < 20; t++) begin
      cycle();
      cnt_a += int'(prs[0][0]);
      cnt_b += int'(prs[1][3]);
    end
    chk("held_reset_press_count", cnt_a, 1);
    chk("held_reset_pending", {31'h0, pnd[0][0]}, 32'h1);
    chk("repeat_pulse_count", cnt_b, 4);

    // Active-low: all four buttons pressed together.
    raw[2] = 4'b0000;
    found  = 0;
    for (int t = 0; t < 12; t++) begin
      cycle();
      if (found == 0 && prs[2] != 4'b0000) begin
        found = 1;
        chk("active_low_all_press", {28'h0, prs[2]}, 32'hF);
      end
    end
    chk("active_low_press_seen", found, 1);

    // Write-one-to-clear.
    clr[0] = 4'b0001;
    cycle();
    clr[0] = 4'b0000;
    chk("clr_pending", {31'h0, pnd[0][0]}, 32'h0);

    // Clear coincident with a press pulse: set wins.
    raw[0] = 4'b0011;
    found  = 0;
    for (int t = 0; t < 12 && found == 0; t++) begin
      cycle();
      if (prs[0][1]) found = 1;
    end
    chk("press_for_clr_seen", found, 1);
    clr[0] = 4'b0010;
    cycle();
    clr[0] = 4'b0000;
    chk("clr_vs_press_pending", {31'h0, pnd[0][1]}, 32'h1);

    // Randomised bouncing: short holds exercise bounce rejection, long ones
    // give accepted levels and repeats.
    random_run(1000, 6);
    random_run(1000, 30);

    // Asynchronous reset mid-run, then more traffic.
    #1 rst = 1'b1;
    #1 check_zero();
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    random_run(300, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
